dac_player: RTL and testbench
=============================

# dac_player

Audio playback engine for the codec DAC path. It reads 16-bit samples sequentially from external SRAM, starting at address 0 and ending at a programmable end address, and serializes each word onto the codec's DACDAT line. Timing follows the codec-supplied bclk and daclrc. It is the transmit counterpart of the capture path and uses the same bit packing, so a recorded buffer plays back bit-exact.

## Interface
- AW, 18: SRAM address width.
- DW, 16: sample width; also the number of bits shifted per frame.

Ports:
- bclk  in  1  codec bit clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high.
- daclrc  in  1  codec frame clock (codec is master); asynchronous to our logic, synchronized internally.
- play  in  1  playback enable from control logic; level-sensitive.
- end_addr  in  AW  last address to play, inclusive; sampled at each end-of-buffer compare.
- rd_data  in  DW  SRAM read data; combinationally valid one bclk after addr changes.
- addr  out  AW  SRAM address; driven when play=1, high-Z otherwise (shared bus).
- dacdat  out  1  serial sample to codec.
- done  out  1  high once the final word has been shifted (non-loop build); sticky until play=0 or reset.

## Operation
- Synchronizer:
  - lrc_q[1:0] <= {lrc_q[0], daclrc} each bclk.
  - fall = (lrc_q==2'b10); rise = (lrc_q==2'b01).
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - dacdat=0, done=0.
  - play=1 -> ARM.
- ARM: wait for first rise.
  - On rise: next_word <= rd_data(addr_q); addr_q advances per the end rule below.
  - -> RUN.
- RUN:
  - On fall: shreg <= next_word, bit_cnt <= 0; shifting begins.
  - Shifting: dacdat <= shreg[bit_cnt] for bit_cnt 0..DW-1, bit 0 first, one bit per bclk. After bit DW-1, dacdat <= 0 until the next fall.
  - On rise: next_word <= rd_data; addr_q advances.
  - One word per frame, transmitted in the low (left) half of daclrc; the high half carries zeros.
- End rule, applied when advancing with addr_q==end_addr:
  - DAC_LOOP_EN undefined: addr_q holds; last_flag set; the word shifts normally; after its bit DW-1 -> DONE.
  - DAC_LOOP_EN defined: addr_q wraps to 0.
- DONE:
  - done=1, dacdat=0, addr_q held.
  - play=0 -> IDLE.
- Address arithmetic: addr_q+1, modulo 2^AW. end_addr=2^AW-1 plays the full memory.
- play=0 in any state:
  - -> IDLE next cycle; shifting aborts; dacdat=0.
  - addr_q is retained (pause/resume). Only reset clears addr_q.
- reset, at any time: state IDLE, addr_q=0, bit_cnt=0, shreg=0, next_word=0, last_flag=0, lrc_q=0, dacdat=0, done=0.

## Timing
- daclrc edge to detection: 2 bclk (synchronizer).
- fall detected in cycle N -> dacdat shows bit 0 in cycle N+1; bit 15 appears in N+16.
- rise detected in cycle M -> addr changes at M+1; rd_data is used at the next rise, so SRAM has ≥ one half-frame to settle.
- rise and fall can never be detected in the same cycle. A fall arriving mid-shift (frame shorter than DW+2 bclk) restarts shifting from bit 0 with the new next_word.
- done asserts the cycle after the final bit DW-1 is driven.

## Configuration
- DAC_LOOP_EN:
  - Defined: continuous loop playback, wrapping end_addr -> 0; done is tied to 0 and DONE is unreachable.
  - Undefined: single-shot playback, as described under End rule.

## Structure
- Shared package audio_pkg:
  - AW/DW defaults.
  - State enum dac_state_t {IDLE, ARM, RUN, DONE}.
  - Edge-pattern constants LRC_FALL=2'b10, LRC_RISE=2'b01. The capture block uses the same constants.
- Sub-module lrc_edge_det: 2-flop synchronizer producing rise/fall pulses; reusable by the capture path.
- Top-level dac_player holds the FSM, address counter and serializer.

## Test plan
- Reset with play=1, SRAM[0]=16'hA5C3 -> addr=0, dacdat=0, done=0; after the first rise then fall, dacdat emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (bit 0 first).
- end_addr=2, SRAM {0:16'h0001, 1:16'h8000, 2:16'hFFFF}, non-loop -> three words serialized correctly, done rises one cycle after the final bit of 16'hFFFF, and addr holds at 2.
- Same stimulus with DAC_LOOP_EN -> fourth frame replays 16'h0001 from addr 0; done stays 0.
- play dropped mid-word at bit 5 -> dacdat=0 next cycle and addr goes high-Z; play re-asserted resumes at the retained addr with a full word from bit 0.
- Synchronous reset asserted mid-shift -> all outputs return to reset values next cycle and addr_q=0.
- Short frame (fall 10 bclk after the previous fall) -> shifting restarts at bit 0 with no X on dacdat.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the codec DAC player and capture path.
// The capture path uses the same daclrc edge patterns, so a recorded buffer plays back bit-exact.
package audio_pkg;

   localparam int AUDIO_AW = 18;
   localparam int AUDIO_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN,
      DONE
   } dac_state_t;

   localparam logic [1:0] LRC_FALL = 2'b10;
   localparam logic [1:0] LRC_RISE = 2'b01;

endpackage

// File: rtl/lrc_edge_det.sv
// Two-flop synchronizer for the codec frame clock.
// Produces single-cycle rise/fall pulses in the bclk domain.
module lrc_edge_det
   import audio_pkg::*;
(
   input  logic bclk,
   input  logic reset,
   input  logic lrc,
   output logic rise,
   output logic fall
);

   logic [1:0] lrc_q;

   always_ff @(posedge bclk) begin
      if (reset) lrc_q <= 2'b00;
      else       lrc_q <= {lrc_q[0], lrc};
   end

   assign fall = (lrc_q == LRC_FALL);
   assign rise = (lrc_q == LRC_RISE);

endmodule

// File: rtl/dac_player.sv
// Codec DAC playback engine: fetches SRAM words from address 0 up to end_addr and shifts them out LSB first.
// Define DAC_LOOP_EN for continuous loop playback; otherwise playback stops after end_addr and raises done.
module dac_player
   import audio_pkg::*;
#(
   parameter int AW = AUDIO_AW,
   parameter int DW = AUDIO_DW
) (
   input  logic          bclk,
   input  logic          reset,
   input  logic          daclrc,
   input  logic          play,
   input  logic [AW-1:0] end_addr,
   input  logic [DW-1:0] rd_data,
   output logic [AW-1:0] addr,
   output logic          dacdat,
   output logic          done
);

   localparam int CW = $clog2(DW + 1);
   localparam int IW = $clog2(DW);
   localparam logic [CW-1:0] CNT_END = CW'(DW);

   dac_state_t state, state_next;
   logic [AW-1:0] addr_q, addr_adv;
   logic [DW-1:0] next_word, shreg;
   logic [CW-1:0] bit_cnt;
   logic          active, last_flag, shift_last, dacdat_q, done_c;
   logic          at_end, word_end, rise, fall;

   lrc_edge_det u_edge (
      .bclk  (bclk),
      .reset (reset),
      .lrc   (daclrc),
      .rise  (rise),
      .fall  (fall)
   );

   assign at_end   = (addr_q == end_addr);
   assign word_end = active && (bit_cnt == CNT_END);

`ifdef DAC_LOOP_EN
   assign addr_adv = at_end ? '0 : addr_q + 1'b1;
`else
   assign addr_adv = at_end ? addr_q : addr_q + 1'b1;
`endif

   always_ff @(posedge bclk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // last_flag is never set in the loop build, which leaves DONE unreachable.
   always_comb begin
      state_next = state;
      done_c     = 1'b0;
      case (state)
         IDLE: if (play) state_next = ARM;
         ARM: begin
            if (!play)     state_next = IDLE;
            else if (rise) state_next = RUN;
         end
         RUN: begin
            if (!play)                                  state_next = IDLE;
            else if (word_end && shift_last && !fall)   state_next = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (!play) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit 0 is driven on the cycle after the fall, so bit_cnt counts the next bit to send.
   always_ff @(posedge bclk) begin
      if (reset) begin
         addr_q     <= '0;
         next_word  <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         active     <= 1'b0;
         last_flag  <= 1'b0;
         shift_last <= 1'b0;
         dacdat_q   <= 1'b0;
      end else begin
         dacdat_q <= 1'b0;
         if (play && (state == ARM || state == RUN) && rise) begin
            next_word <= rd_data;
            addr_q    <= addr_adv;
`ifndef DAC_LOOP_EN
            if (at_end) last_flag <= 1'b1;
`endif
         end
         if (play && state == RUN) begin
            if (fall) begin
               shreg      <= next_word;
               dacdat_q   <= next_word[0];
               bit_cnt    <= CW'(1);
               active     <= 1'b1;
               shift_last <= last_flag;
            end else if (active) begin
               if (word_end) begin
                  active <= 1'b0;
               end else begin
                  dacdat_q <= shreg[bit_cnt[IW-1:0]];
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign addr   = play ? addr_q : {AW{1'bz}};
   assign dacdat = dacdat_q;

`ifdef DAC_LOOP_EN
   assign done = 1'b0;
`else
   assign done = done_c;
`endif

endmodule

// File: tb/tb_dac_player.sv
// Directed self-checking bench for dac_player: serialization, end-of-buffer, pause, reset and short frames.
// Builds with or without DAC_LOOP_EN; expectations follow the selected build.
module tb_dac_player;

`ifdef DAC_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic        bclk = 1'b0;
   logic        reset, daclrc, play;
   logic [17:0] end_addr;
   logic [15:0] rd_data;
   tri1  [17:0] addr_bus;
   logic        dacdat, done;

   logic [15:0] mem [0:15];
   logic        dac_hist  [0:4095];
   logic        done_hist [0:4095];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 bclk = ~bclk;

   assign rd_data = mem[addr_bus[3:0]];

   dac_player dut (
      .bclk     (bclk),
      .reset    (reset),
      .daclrc   (daclrc),
      .play     (play),
      .end_addr (end_addr),
      .rd_data  (rd_data),
      .addr     (addr_bus),
      .dacdat   (dacdat),
      .done     (done)
   );

   // Log serial output and done at every negedge, indexed by negedge number.
   always @(negedge bclk) begin
      int idx;
      idx = int'($time / 10);
      if (idx < 4096) begin
         dac_hist[idx]  = dacdat;
         done_hist[idx] = done;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   // Drive daclrc at the current negedge, report its negedge index, then hold for n cycles.
   task automatic drv_lrc(input logic lvl, input int n, output int e);
      daclrc = lvl;
      e = int'($time / 10);
      repeat (n) @(negedge bclk);
   endtask

   task automatic do_reset;
      daclrc = 1'b0;
      reset  = 1'b1;
      repeat (2) @(negedge bclk);
   endtask

   function automatic logic [15:0] get_word(input int e);
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[k] = dac_hist[e + 2 + k];
      return w;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int e, e0, e1, e2, e3, ea, eb;
      logic [15:0] w;
      reset = 1'b1; play = 1'b0; daclrc = 1'b0; end_addr = 18'd5;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      @(negedge bclk);

      // Reset with play high, then one word of 16'hA5C3
      mem[0] = 16'hA5C3;
      play = 1'b1;
      do_reset();
      chk("rst_addr",   32'(addr_bus), 32'd0);
      chk("rst_dacdat", 32'(dacdat),   32'd0);
      chk("rst_done",   32'(done),     32'd0);
      reset = 1'b0;
      drv_lrc(1'b0, 4, e);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 20, e0);
      drv_lrc(1'b1, 20, e);
      chk("t1_word", 32'(get_word(e0)), 32'h0000A5C3);
      chk("t1_tail", 32'(dac_hist[e0 + 18]), 32'd0);
      chk("t1_addr", 32'(addr_bus), 32'd2);

      // End of buffer at address 2
      mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hFFFF;
      end_addr = 18'd2;
      do_reset();
      reset = 1'b0;
      drv_lrc(1'b0, 4, e);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 20, e1); drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 20, e2); drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 20, e3); drv_lrc(1'b1, 20, e);
      chk("t2_w0", 32'(get_word(e1)), 32'h00000001);
      chk("t2_w1", 32'(get_word(e2)), 32'h00008000);
      chk("t2_w2", 32'(get_word(e3)), 32'h0000FFFF);
      chk("t2_done_b15", 32'(done_hist[e3 + 17]), 32'd0);
      chk("t2_done_end", 32'(done_hist[e3 + 18]), LOOP ? 32'd0 : 32'd1);
      drv_lrc(1'b0, 20, e0); drv_lrc(1'b1, 20, e);
      chk("t2_w3", 32'(get_word(e0)), LOOP ? 32'h00000001 : 32'h00000000);
      chk("t2_done_w3", 32'(done_hist[e0 + 18]), LOOP ? 32'd0 : 32'd1);
      chk("t2_addr", 32'(addr_bus), 32'd2);
      play = 1'b0;
      @(negedge bclk);
      chk("t2_stop_done", 32'(done),     32'd0);
      chk("t2_stop_addr", 32'(addr_bus), 32'h0003FFFF);
      chk("t2_stop_dat",  32'(dacdat),   32'd0);

      // Pause at bit 5, resume at the retained address
      mem[0] = 16'h1357; mem[1] = 16'h2468;
      end_addr = 18'd5;
      play = 1'b1;
      do_reset();
      reset = 1'b0;
      drv_lrc(1'b0, 4, e);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 7, e0);
      play = 1'b0;
      drv_lrc(1'b0, 13, e);
      w = get_word(e0);
      chk("t3_bits", 32'(w[5:0]), 32'h17);
      chk("t3_dat0", 32'(dac_hist[e0 + 8]), 32'd0);
      chk("t3_hiz",  32'(addr_bus), 32'h0003FFFF);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 3, e);
      play = 1'b1;
      drv_lrc(1'b0, 5, e);
      chk("t3_addr", 32'(addr_bus), 32'd1);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 20, e1); drv_lrc(1'b1, 20, e);
      chk("t3_word", 32'(get_word(e1)), 32'h00002468);

      // Synchronous reset mid-shift
      drv_lrc(1'b0, 7, e);
      reset = 1'b1;
      @(negedge bclk);
      chk("t4_dat",  32'(dacdat),   32'd0);
      chk("t4_done", 32'(done),     32'd0);
      chk("t4_addr", 32'(addr_bus), 32'd0);
      reset = 1'b0;

      // Short frame: fall 10 bclk after the previous fall
      mem[0] = 16'hA5C3; mem[1] = 16'h3C96;
      do_reset();
      reset = 1'b0;
      drv_lrc(1'b0, 4, e);
      drv_lrc(1'b1, 20, e);
      drv_lrc(1'b0, 5, ea);
      drv_lrc(1'b1, 5, e);
      drv_lrc(1'b0, 20, eb);
      drv_lrc(1'b1, 20, e);
      w = get_word(ea);
      chk("t5_part", 32'(w[9:0]), 32'h000001C3);
      chk("t5_word", 32'(get_word(eb)), 32'h00003C96);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
